// File: rtl/commit_trace_unit_if.sv
// Commit-trace record channel between the trace producer and its consumer.
// The producer (master) drives ev_valid and the record fields; the consumer
// (slave) drives ev_ready. A record transfers on a cycle where both are high.
//   ev_valid  record available
//   ev_ready  consumer accepts record
//   ev_flags  {halt, mem_write, mem_read, reg_write}
//   ev_reg    destination register number
//   ev_wdata  register write data
//   ev_addr   memory address
//   ev_mdata  memory data (store data or load data)
interface commit_trace_unit_if;
  logic        ev_valid;
  logic        ev_ready;
  logic [3:0]  ev_flags;
  logic [2:0]  ev_reg;
  logic [15:0] ev_wdata;
  logic [15:0] ev_addr;
  logic [15:0] ev_mdata;

  modport master (
    output ev_valid, ev_flags, ev_reg, ev_wdata, ev_addr, ev_mdata,
    input  ev_ready
  );

  modport slave (
    input  ev_valid, ev_flags, ev_reg, ev_wdata, ev_addr, ev_mdata,
    output ev_ready
  );
endinterface

// File: rtl/commit_trace_unit.sv
// Commit-trace producer. Samples retire events from the MEM/WB stage, packs
// each into a record, buffers records in a first-word-fall-through FIFO and
// hands them to a consumer over the ev channel. Keeps saturating performance
// counters. A retired HALT moves the unit to DRAIN; once the FIFO empties it
// reaches DONE and holds done until reset.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   RegWrite_in..Halt_in     retire event fields
//   ICache*/DCache*          cache request/hit strobes
//   ev                       record channel (master side)
//   stall_out                FIFO full, pipeline must hold retire
//   overflow                 sticky: a record was dropped
//   *_cnt                    saturating performance counters
//   halted, done             halt record captured / halt captured and drained
module commit_trace_unit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWrite_in,
  input  logic [2:0]       WrReg_in,
  input  logic [15:0]      WrData_in,
  input  logic             MemRead_in,
  input  logic             MemWrite_in,
  input  logic [15:0]      MemAddr_in,
  input  logic [15:0]      MemDataIn_in,
  input  logic [15:0]      MemDataOut_in,
  input  logic             Halt_in,
  input  logic             ICacheReq_in,
  input  logic             ICacheHit_in,
  input  logic             DCacheReq_in,
  input  logic             DCacheHit_in,
  commit_trace_unit_if.master ev,
  output logic             stall_out,
  output logic             overflow,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] inst_cnt,
  output logic [CNT_W-1:0] ic_req_cnt,
  output logic [CNT_W-1:0] ic_hit_cnt,
  output logic [CNT_W-1:0] dc_req_cnt,
  output logic [CNT_W-1:0] dc_hit_cnt,
  output logic             halted,
  output logic             done
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic [3:0]  flags;
    logic [2:0]  rnum;
    logic [15:0] wdata;
    logic [15:0] addr;
    logic [15:0] mdata;
  } rec_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e           state_q, state_d;
  rec_t             mem_q [DEPTH];
  rec_t             rec_d, head;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, halted_q;
  logic [CNT_W-1:0] cycle_q, inst_q, icr_q, ich_q, dcr_q, dch_q;
  logic             running, event_w, pop, push, drop;

  assign running = (state_q == S_RUN);
  assign event_w = running & (RegWrite_in | MemRead_in | MemWrite_in | Halt_in);
  assign pop     = ev.ev_valid & ev.ev_ready;
  // A full FIFO still accepts a record when the head leaves in the same cycle.
  assign push    = event_w & ((count_q != FULL) | pop);
  assign drop    = event_w & (count_q == FULL) & ~pop;

  always_comb begin
    rec_d.flags = {Halt_in, MemWrite_in, MemRead_in, RegWrite_in};
    rec_d.rnum  = WrReg_in;
    rec_d.wdata = WrData_in;
    rec_d.addr  = MemAddr_in;
    // Store data wins when an instruction both reads and writes memory.
    if (MemWrite_in)     rec_d.mdata = MemDataIn_in;
    else if (MemRead_in) rec_d.mdata = MemDataOut_in;
    else                 rec_d.mdata = '0;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (push && Halt_in) state_d = S_DRAIN;
      S_DRAIN: if (count_q == '0)   state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      halted_q   <= 1'b0;
      cycle_q    <= '0;
      inst_q     <= '0;
      icr_q      <= '0;
      ich_q      <= '0;
      dcr_q      <= '0;
      dch_q      <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (drop) overflow_q <= 1'b1;
      if (push && Halt_in) halted_q <= 1'b1;
      // Pure loads are traced but are not counted as instructions.
      if (push && (RegWrite_in || MemWrite_in || Halt_in)) inst_q <= sat_inc(inst_q);
      if (running) begin
        cycle_q <= sat_inc(cycle_q);
        if (ICacheReq_in) icr_q <= sat_inc(icr_q);
        if (ICacheHit_in) ich_q <= sat_inc(ich_q);
        if (DCacheReq_in) dcr_q <= sat_inc(dcr_q);
        if (DCacheHit_in) dch_q <= sat_inc(dch_q);
      end
    end
  end

  // NOTE: the storage array is not reset; entries are only observed through
  // the head when count_q says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rec_d;
  end

  // Fields read as zero while empty so reset leaves all data outputs at 0.
  assign ev.ev_valid = (count_q != '0);
  assign head        = ev.ev_valid ? mem_q[rd_ptr_q] : '0;
  assign ev.ev_flags = head.flags;
  assign ev.ev_reg   = head.rnum;
  assign ev.ev_wdata = head.wdata;
  assign ev.ev_addr  = head.addr;
  assign ev.ev_mdata = head.mdata;

  assign stall_out  = (count_q == FULL);
  assign overflow   = overflow_q;
  assign halted     = halted_q;
  assign done       = (state_q == S_DONE);
  assign cycle_cnt  = cycle_q;
  assign inst_cnt   = inst_q;
  assign ic_req_cnt = icr_q;
  assign ic_hit_cnt = ich_q;
  assign dc_req_cnt = dcr_q;
  assign dc_hit_cnt = dch_q;
endmodule
